fifo_button_ctrl: RTL and testbench
===================================

Name: fifo_button_ctrl

Overview:
Front-end controller sequencing the button-driven FIFO. It synchronizes and debounces the raw write/read push buttons and converts each clean press into at most one single-cycle write or read strobe. It arbitrates simultaneous requests and blocks writes when the FIFO is full and reads when it is empty. It sits between the board buttons and the fifo block's write/read enables.

Parameters:
DB_CYCLES, 4, consecutive clk cycles a synchronized level must hold before the debounced level changes (legal values 2..2**CNT_W).
CNT_W, 3, width of each debounce counter.

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  asynchronous, active-high reset.
button_wrd  input  1  raw write button, asynchronous, bouncy.
button_red  input  1  raw read button, asynchronous, bouncy.
fifo_full  input  1  FIFO full flag; registered in FIFO, valid the cycle after a strobe.
fifo_empty  input  1  FIFO empty flag; registered in FIFO, valid the cycle after a strobe.
wr_en  output  1  one-cycle write strobe to FIFO.
rd_en  output  1  one-cycle read strobe to FIFO.
wr_drop  output  1  one-cycle pulse: write press discarded because FIFO full.
rd_drop  output  1  one-cycle pulse: read press discarded because FIFO empty.

Behaviour:
- Reset (clr high, async): all sync flops, debounced levels, counters, pending flags = 0; prio = write; wr_en, rd_en, wr_drop, rd_drop = 0.
- Per button: 2-flop synchronizer (s1, s2), then debouncer FSM with states LOW, WAIT_HIGH, HIGH, WAIT_LOW.
  - LOW: s2=1 -> WAIT_HIGH, cnt=1.
  - WAIT_HIGH: s2=0 -> LOW, cnt=0. If s2=1 and cnt==DB_CYCLES-1 -> HIGH, set pending. Otherwise cnt+1.
  - HIGH: s2=0 -> WAIT_LOW, cnt=1.
  - WAIT_LOW: s2=1 -> HIGH. If s2=0 and cnt==DB_CYCLES-1 -> LOW. Otherwise cnt+1.
  - Glitches shorter than DB_CYCLES cycles never change state. Pending is set only on the WAIT_HIGH->HIGH transition. Holding the button produces exactly one request.
- Latency: if edge N is the first edge sampling the button high, and it stays high, the button enters HIGH at edge N+DB_CYCLES+1. The strobe is registered and high for the cycle after edge N+DB_CYCLES+2.
- A pending flag is a single bit. A new press while the same flag is still set is merged, not queued.
- Arbiter, one decision per cycle, registered outputs:
  - Only wr_pend: if !fifo_full, wr_en=1; else wr_drop=1. Clear wr_pend either way.
  - Only rd_pend: if !fifo_empty, rd_en=1; else rd_drop=1. Clear rd_pend either way.
  - Both pending: serve the side given by prio; the other side is served the next cycle. After a grant or drop, prio toggles to the other side.
  - Never wr_en and rd_en in the same cycle. At most one of the four outputs is high per cycle.
- Full/empty are sampled in the decision cycle. Back-to-back strobes rely on the flags updating one cycle after a strobe.
- Reset mid-operation clears pending requests and aborts debounce; no strobe is emitted from a pre-reset press. A button held through reset release yields one press after debounce.

Test Plan:
- Reset, DB_CYCLES=4, 20 ns clk: press button_wrd clean for 200 ns, FIFO empty -> exactly one wr_en pulse, 20 ns wide, in the cycle after edge N+6; no further strobes while held.
- Bounce: button_wrd toggles 4/8/8 ns then holds 200 ns -> exactly one wr_en. Isolated 30 ns pulses (<4 cycles) -> no wr_en.
- Write 0x01 then 0x04, release, press button_red -> one rd_en. Second press -> second rd_en. Third press with fifo_empty=1 -> rd_drop pulse, no rd_en.
- Tie fifo_full=1, press write -> wr_drop only. Deassert full, press again -> wr_en.
- Release both buttons into HIGH on the same edge, flags clear -> wr_en in cycle t, rd_en in cycle t+1. Repeat -> rd_en first, then wr_en (prio alternates).
- Assert clr for 1 cycle while button_red in WAIT_HIGH (cnt=2) -> no rd_en. Button still held -> rd_en 6 cycles after clr release; all outputs 0 during clr.

Source files
------------

// File: rtl/fifo_button_ctrl.sv
// Button front-end for the FIFO: synchronizes and debounces the write/read buttons,
// then arbitrates clean presses into single-cycle strobes or full/empty drop pulses.
module fifo_button_ctrl #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic button_wrd,
    input  logic button_red,
    input  logic fifo_full,
    input  logic fifo_empty,
    output logic wr_en,
    output logic rd_en,
    output logic wr_drop,
    output logic rd_drop
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    // Index 0 is the write button, index 1 the read button.
    logic [1:0]       s1;
    logic [1:0]       s2;
    db_state_t        state     [2];
    db_state_t        state_nxt [2];
    logic [CNT_W-1:0] cnt       [2];
    logic [CNT_W-1:0] cnt_nxt   [2];
    logic [1:0]       press;
    logic [1:0]       pend;
    logic [1:0]       pend_clr;
    logic             prio_rd;
    logic             prio_rd_nxt;
    logic             wr_en_nxt;
    logic             rd_en_nxt;
    logic             wr_drop_nxt;
    logic             rd_drop_nxt;

    // State, synchronizer, pending and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1      <= '0;
            s2      <= '0;
            pend    <= '0;
            prio_rd <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            wr_drop <= 1'b0;
            rd_drop <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= LOW;
                cnt[i]   <= '0;
            end
        end else begin
            s1      <= {button_red, button_wrd};
            s2      <= s1;
            pend    <= (pend & ~pend_clr) | press;
            prio_rd <= prio_rd_nxt;
            wr_en   <= wr_en_nxt;
            rd_en   <= rd_en_nxt;
            wr_drop <= wr_drop_nxt;
            rd_drop <= rd_drop_nxt;
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Debouncers: a level must persist DB_CYCLES samples; only a completed rise is a press
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            press[i]     = 1'b0;
            case (state[i])
                LOW: begin
                    if (s2[i]) begin
                        state_nxt[i] = WAIT_HIGH;
                        cnt_nxt[i]   = CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!s2[i]) begin
                        state_nxt[i] = LOW;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = HIGH;
                        cnt_nxt[i]   = '0;
                        press[i]     = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!s2[i]) begin
                        state_nxt[i] = WAIT_LOW;
                        cnt_nxt[i]   = CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (s2[i]) begin
                        state_nxt[i] = HIGH;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = LOW;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = LOW;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Arbiter: one decision per cycle; priority flips only when both sides contended
    always_comb begin
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        wr_drop_nxt = 1'b0;
        rd_drop_nxt = 1'b0;
        pend_clr    = '0;
        prio_rd_nxt = prio_rd;
        if (pend[0] && (!pend[1] || !prio_rd)) begin
            pend_clr[0] = 1'b1;
            wr_en_nxt   = !fifo_full;
            wr_drop_nxt = fifo_full;
            if (pend[1]) begin
                prio_rd_nxt = 1'b1;
            end
        end else if (pend[1]) begin
            pend_clr[1] = 1'b1;
            rd_en_nxt   = !fifo_empty;
            rd_drop_nxt = fifo_empty;
            if (pend[0]) begin
                prio_rd_nxt = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_button_ctrl.sv
// Testbench for fifo_button_ctrl: directed latency/priority/reset steps plus
// randomized buttons and flags, checked every cycle against a reference model.
module tb_fifo_button_ctrl;

    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic clr;
    logic button_wrd;
    logic button_red;
    logic fifo_full;
    logic fifo_empty;
    logic wr_en;
    logic rd_en;
    logic wr_drop;
    logic rd_drop;

    int checks = 0;
    int errors = 0;

    fifo_button_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .button_wrd (button_wrd),
        .button_red (button_red),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_drop    (wr_drop),
        .rd_drop    (rd_drop)
    );

    always #10 clk = ~clk;

    // Reference model: raw samples reach the debouncer two edges late; a debounced
    // level flips after DB consecutive samples disagree with it; rises become requests.
    bit       m_d1   [2];
    bit       m_d2   [2];
    bit       m_lvl  [2];
    int       m_run  [2];
    bit       m_pend [2];
    bit       m_prio_rd;
    bit [3:0] m_out;   // {wr_en, rd_en, wr_drop, rd_drop}

    task automatic model_edge();
        bit raw [2];
        bit rise [2];
        raw[0] = button_wrd;
        raw[1] = button_red;
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_pend[i] = 0;
            end
            m_prio_rd = 0;
            m_out = 4'b0000;
            return;
        end
        m_out = 4'b0000;
        if (m_pend[0] && m_pend[1]) begin
            if (m_prio_rd) begin
                m_out = fifo_empty ? 4'b0001 : 4'b0100;
                m_pend[1] = 0;
            end else begin
                m_out = fifo_full ? 4'b0010 : 4'b1000;
                m_pend[0] = 0;
            end
            m_prio_rd = !m_prio_rd;
        end else if (m_pend[0]) begin
            m_out = fifo_full ? 4'b0010 : 4'b1000;
            m_pend[0] = 0;
        end else if (m_pend[1]) begin
            m_out = fifo_empty ? 4'b0001 : 4'b0100;
            m_pend[1] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            rise[i] = 0;
            if (m_d2[i] != m_lvl[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == int'(DB)) begin
                m_lvl[i] = m_d2[i];
                m_run[i] = 0;
                rise[i]  = m_lvl[i];
            end
            if (rise[i]) m_pend[i] = 1;
            m_d2[i] = m_d1[i];
            m_d1[i] = raw[i];
        end
    endtask

    // One clock: model at the edge, compare 1 ns later, return at the falling edge
    task automatic cycle();
        bit [3:0] obs;
        @(posedge clk);
        model_edge();
        #1;
        obs = {wr_en, rd_en, wr_drop, rd_drop};
        checks++;
        assert (obs === m_out) else begin
            errors++;
            $error("FAIL outputs t=%0t observed=%b expected=%b", $time, obs, m_out);
        end
        checks++;
        assert ($countones(obs) <= 1) else begin
            errors++;
            $error("FAIL onehot t=%0t observed=%b expected=at_most_one_high", $time, obs);
        end
        @(negedge clk);
    endtask

    // Fixed-length window; reports edge index of the first wr_en/rd_en, or -1
    task automatic wait_strobe(output int lat, output bit was_rd);
        lat = -1;
        was_rd = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (lat < 0 && (wr_en || rd_en)) begin
                lat = k;
                was_rd = rd_en;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    int hold_w;
    int hold_r;
    int hold_f;
    int lat;
    bit was_rd;

    initial begin
        clr = 1'b1; button_wrd = 0; button_red = 0; fifo_full = 0; fifo_empty = 0;
        cycle();
        checks++;
        assert ({wr_en, rd_en, wr_drop, rd_drop} === 4'b0000) else begin
            errors++;
            $error("FAIL reset_outputs observed=%b expected=0000", {wr_en, rd_en, wr_drop, rd_drop});
        end
        clr = 1'b0;
        idle(5);

        // Clean write press: strobe after the seventh edge, only once while held
        button_wrd = 1;
        wait_strobe(lat, was_rd);
        checks++;
        assert (lat === int'(DB) + 3) else begin
            errors++;
            $error("FAIL wr_latency observed=%0d expected=%0d", lat, DB + 3);
        end
        button_wrd = 0;
        idle(10);

        // Bounce then hold: a single write strobe
        for (int k = 0; k < 3; k++) begin button_wrd = ~button_wrd; cycle(); end
        button_wrd = 1;
        idle(15);
        button_wrd = 0;
        idle(10);

        // Short pulses never become requests
        for (int k = 0; k < 4; k++) begin
            button_wrd = 1; idle(2); button_wrd = 0; idle(2);
        end
        idle(10);

        // Full blocks writes, empty blocks reads
        fifo_full = 1; button_wrd = 1; idle(12); button_wrd = 0; idle(8);
        fifo_full = 0; fifo_empty = 1; button_red = 1; idle(12); button_red = 0; idle(8);
        fifo_empty = 0;

        // Simultaneous presses: write first, then read first on the repeat
        button_wrd = 1; button_red = 1;
        wait_strobe(lat, was_rd);
        checks++;
        assert (was_rd === 1'b0 && lat === int'(DB) + 3) else begin
            errors++;
            $error("FAIL order1 observed=rd%0b@%0d expected=rd0@%0d", was_rd, lat, DB + 3);
        end
        button_wrd = 0; button_red = 0; idle(10);
        button_wrd = 1; button_red = 1;
        wait_strobe(lat, was_rd);
        checks++;
        assert (was_rd === 1'b1 && lat === int'(DB) + 3) else begin
            errors++;
            $error("FAIL order2 observed=rd%0b@%0d expected=rd1@%0d", was_rd, lat, DB + 3);
        end
        button_wrd = 0; button_red = 0; idle(10);

        // Reset while read is debouncing; the held button yields one read afterwards
        button_red = 1;
        idle(4);
        clr = 1;
        cycle();
        checks++;
        assert ({wr_en, rd_en, wr_drop, rd_drop} === 4'b0000) else begin
            errors++;
            $error("FAIL clr_outputs observed=%b expected=0000", {wr_en, rd_en, wr_drop, rd_drop});
        end
        clr = 0;
        wait_strobe(lat, was_rd);
        checks++;
        assert (was_rd === 1'b1 && lat === int'(DB) + 3) else begin
            errors++;
            $error("FAIL clr_recover observed=rd%0b@%0d expected=rd1@%0d", was_rd, lat, DB + 3);
        end
        button_red = 0;
        idle(10);

        // Randomized buttons, flags and occasional reset
        hold_w = 0; hold_r = 0; hold_f = 0;
        for (int n = 0; n < 4000; n++) begin
            if (hold_w == 0) begin
                button_wrd = 1'($urandom_range(0, 1));
                hold_w = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14)));
            end else hold_w--;
            if (hold_r == 0) begin
                button_red = 1'($urandom_range(0, 1));
                hold_r = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14)));
            end else hold_r--;
            if (hold_f == 0) begin
                fifo_full  = ($urandom_range(0, 3) == 0);
                fifo_empty = fifo_full ? 1'b0 : ($urandom_range(0, 3) == 0);
                hold_f = int'($urandom_range(1, 10));
            end else hold_f--;
            clr = ($urandom_range(0, 399) == 0);
            cycle();
        end
        clr = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
